// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the N-tap FIR filter.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        SHIFT,
        MAC,
        DONE
    } state_t;

    // Unity gain in the default 16-bit unsigned Q1.15 coefficient format.
    localparam logic [15:0] ONE_Q = 16'h8000;

    // Signed accumulator width that can hold NUM_TAPS full-scale products without wrapping.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned num_taps);
        return data_w + $clog2(num_taps) + 2;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous request, followed by a rising-edge detector.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    // [1:0] synchronizer chain, [2] previous synchronized value for edge detection
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fir_filter_n.sv
// N-tap FIR filter: serial sign-masked MAC over a delay line, coefficients loaded one at a
// time, with optional output saturation and a periodic sample-count pulse.
module fir_filter_n
    import fir_pkg::*;
#(
    parameter int unsigned         NUM_TAPS     = 4,
    parameter int unsigned         DATA_W       = 16,
    parameter logic [NUM_TAPS-1:0] SUB_MASK     = 'b1010,
    parameter int unsigned         SAMPLE_LIMIT = 1000,
    parameter bit                  SAT_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] fir_coefficient,
    input  logic              load_coeff,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_out,
    output logic              err,
    output logic              one_k_samples
);

    localparam int unsigned ACC_W  = acc_width(DATA_W, NUM_TAPS);
    localparam int unsigned IDX_W  = $clog2(NUM_TAPS);
    localparam int unsigned CNT_W  = $clog2(SAMPLE_LIMIT + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(SAMPLE_LIMIT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'({DATA_W{1'b1}});

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         mac_idx_q, mac_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        coeff_q [NUM_TAPS];
    logic [DATA_W-1:0]        coeff_d [NUM_TAPS];
    logic [DATA_W-1:0]        tap_q   [NUM_TAPS];
    logic [DATA_W-1:0]        tap_d   [NUM_TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        fir_out_q, fir_out_d;
    logic                     err_q, err_d;
    logic                     one_k_q, one_k_d;

    logic                     coeff_rise;
    logic                     data_rise;
    logic [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]  scaled;

    sync_edge_det u_sync_coeff (
        .clk_i   (clk),
        .rst_i   (reset),
        .async_i (load_coeff),
        .rise_o  (coeff_rise)
    );

    sync_edge_det u_sync_data (
        .clk_i   (clk),
        .rst_i   (reset),
        .async_i (data_ready),
        .rise_o  (data_rise)
    );

    // Product is Q1.(DATA_W-1) scaled back to sample units; always non-negative.
    always_comb begin
        prod   = PROD_W'(tap_q[mac_idx_q]) * PROD_W'(coeff_q[mac_idx_q]);
        scaled = ACC_W'(prod >> (DATA_W - 1));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mac_idx_d = mac_idx_q;
        cnt_d     = cnt_q;
        coeff_d   = coeff_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        fir_out_d = fir_out_q;
        err_d     = err_q;
        one_k_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A coefficient request wins; a simultaneous sample request is discarded.
                if (coeff_rise) begin
                    state_d = STORE;
                end else if (data_rise) begin
                    state_d = SHIFT;
                end
            end
            STORE: begin
                coeff_d[idx_q] = fir_coefficient;
                idx_d          = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                cnt_d          = '0;
                state_d        = IDLE;
            end
            SHIFT: begin
                tap_d[0] = sample_data;
                for (int i = 1; i < NUM_TAPS; i++) begin
                    tap_d[i] = tap_q[i-1];
                end
                acc_d     = '0;
                mac_idx_d = '0;
                state_d   = MAC;
            end
            MAC: begin
                acc_d = SUB_MASK[mac_idx_q] ? acc_q - scaled : acc_q + scaled;
                if (mac_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    mac_idx_d = mac_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (acc_q[ACC_W-1]) begin
                    err_d     = 1'b1;
                    fir_out_d = SAT_EN ? '0 : acc_q[DATA_W-1:0];
                end else if (acc_q > OUT_MAX) begin
                    err_d     = 1'b1;
                    fir_out_d = SAT_EN ? '1 : acc_q[DATA_W-1:0];
                end else begin
                    err_d     = 1'b0;
                    fir_out_d = acc_q[DATA_W-1:0];
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    one_k_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mac_idx_q <= '0;
            cnt_q     <= '0;
            coeff_q   <= '{default: '0};
            tap_q     <= '{default: '0};
            acc_q     <= '0;
            fir_out_q <= '0;
            err_q     <= 1'b0;
            one_k_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mac_idx_q <= mac_idx_d;
            cnt_q     <= cnt_d;
            coeff_q   <= coeff_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            fir_out_q <= fir_out_d;
            err_q     <= err_d;
            one_k_q   <= one_k_d;
        end
    end

    assign modwait       = (state_q != IDLE);
    assign fir_out       = fir_out_q;
    assign err           = err_q;
    assign one_k_samples = one_k_q;

endmodule

// File: tb/tb_fir_filter_n.sv
// Directed bench for fir_filter_n: several parameterisations driven from shared stimulus,
// each checked against hand-computed results.
module tb_fir_filter_n;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dr;
    logic        lc;
    logic [15:0] sdat;
    logic [15:0] cin;

    logic [15:0] fo_a, fo_b, fo_c, fo_d;
    logic [11:0] fo_w;
    logic        err_a, err_b, err_c, err_d, err_w;
    logic        mw_a, mw_b, mw_c, mw_d, mw_w;
    logic        ok_a, ok_b, ok_c, ok_d, ok_w;

    int          vectors     = 0;
    int          miscompares = 0;
    int          busy;
    logic        onek_at;
    logic        onek_after;

    always #5 clk = ~clk;

    // Add-only, short sample period.
    fir_filter_n #(.SUB_MASK(4'b0000), .SAMPLE_LIMIT(8)) u_a (
        .clk(clk), .reset(reset), .sample_data(sdat), .data_ready(dr),
        .fir_coefficient(cin), .load_coeff(lc), .modwait(mw_a), .fir_out(fo_a),
        .err(err_a), .one_k_samples(ok_a)
    );

    // Default parameters.
    fir_filter_n u_b (
        .clk(clk), .reset(reset), .sample_data(sdat), .data_ready(dr),
        .fir_coefficient(cin), .load_coeff(lc), .modwait(mw_b), .fir_out(fo_b),
        .err(err_b), .one_k_samples(ok_b)
    );

    fir_filter_n #(.SUB_MASK(4'b0010), .SAT_EN(1'b1)) u_c (
        .clk(clk), .reset(reset), .sample_data(sdat), .data_ready(dr),
        .fir_coefficient(cin), .load_coeff(lc), .modwait(mw_c), .fir_out(fo_c),
        .err(err_c), .one_k_samples(ok_c)
    );

    fir_filter_n #(.SUB_MASK(4'b0010), .SAT_EN(1'b0)) u_d (
        .clk(clk), .reset(reset), .sample_data(sdat), .data_ready(dr),
        .fir_coefficient(cin), .load_coeff(lc), .modwait(mw_d), .fir_out(fo_d),
        .err(err_d), .one_k_samples(ok_d)
    );

    fir_filter_n #(.NUM_TAPS(8), .DATA_W(12), .SUB_MASK(8'h00)) u_w (
        .clk(clk), .reset(reset), .sample_data(sdat[11:0]), .data_ready(dr),
        .fir_coefficient(cin[11:0]), .load_coeff(lc), .modwait(mw_w), .fir_out(fo_w),
        .err(err_w), .one_k_samples(ok_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic mw_sel(input bit wide);
        return wide ? mw_w : mw_a;
    endfunction

    task automatic wait_rise(input bit wide);
        int n;
        int lim;
        n   = 0;
        lim = wide ? 32 : 16;
        while (!mw_sel(wide) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("modwait_rise_timeout", 32'(n < lim), 32'd1);
    endtask

    // Counts busy cycles, captures the pulse output on the first idle cycle and the next.
    task automatic wait_fall(input bit wide);
        int lim;
        lim  = wide ? 32 : 16;
        busy = 0;
        while (mw_sel(wide) && busy < lim) begin
            busy++;
            @(negedge clk);
        end
        chk("modwait_fall_timeout", 32'(busy < lim), 32'd1);
        onek_at = ok_a;
        @(negedge clk);
        onek_after = ok_a;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_op(input bit ld, input bit drq, input logic [15:0] c,
                         input logic [15:0] s, input bit wide);
        cin  = c;
        sdat = s;
        lc   = ld;
        dr   = drq;
        wait_rise(wide);
        lc = 1'b0;
        dr = 1'b0;
        wait_fall(wide);
    endtask

    task automatic load_c(input logic [15:0] c, input bit wide);
        do_op(1'b1, 1'b0, c, 16'h0000, wide);
    endtask

    task automatic samp(input logic [15:0] s, input bit wide);
        do_op(1'b0, 1'b1, 16'h0000, s, wide);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dr    = 1'b0;
        lc    = 1'b0;
        sdat  = '0;
        cin   = '0;
        repeat (2) @(negedge clk);
        chk("reset_a", 32'({fo_a, err_a, mw_a, ok_a}), 32'd0);
        chk("reset_b", 32'({fo_b, err_b, mw_b, ok_b}), 32'd0);
        chk("reset_c", 32'({fo_c, err_c, mw_c, ok_c}), 32'd0);
        chk("reset_d", 32'({fo_d, err_d, mw_d, ok_d}), 32'd0);
        chk("reset_w", 32'({fo_w, err_w, mw_w, ok_w}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Half-gain coefficients accumulate 0.5*sample per filled tap.
        do_reset();
        for (int i = 0; i < 4; i++) load_c(ONE_Q >> 1, 1'b0);
        chk("store_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            samp(16'd100, 1'b0);
            chk("s1_out", 32'(fo_a), 32'(50 * k));
            chk("s1_err", 32'(err_a), 32'd0);
            if (k == 1) chk("s1_busy", 32'(busy), 32'd6);
        end

        // Alternating add/subtract taps.
        do_reset();
        for (int i = 0; i < 4; i++) load_c(ONE_Q, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            samp(16'd100, 1'b0);
            chk("s2_out", 32'(fo_b), (k % 2 == 1) ? 32'd100 : 32'd0);
            chk("s2_err", 32'(err_b), 32'd0);
        end

        // Negative result: clamp versus truncate.
        do_reset();
        load_c(ONE_Q, 1'b0);
        load_c(ONE_Q, 1'b0);
        load_c(16'h0000, 1'b0);
        load_c(16'h0000, 1'b0);
        samp(16'd100, 1'b0);
        chk("s3_sat_out0", 32'(fo_c), 32'd100);
        chk("s3_sat_err0", 32'(err_c), 32'd0);
        chk("s3_trn_out0", 32'(fo_d), 32'd100);
        chk("s3_trn_err0", 32'(err_d), 32'd0);
        samp(16'd50, 1'b0);
        chk("s3_sat_out1", 32'(fo_c), 32'd0);
        chk("s3_sat_err1", 32'(err_c), 32'd1);
        chk("s3_trn_out1", 32'(fo_d), 32'h0000FFCE);
        chk("s3_trn_err1", 32'(err_d), 32'd1);

        // Full-scale boundary then overflow.
        do_reset();
        for (int i = 0; i < 4; i++) load_c(ONE_Q, 1'b0);
        samp(16'hFFFF, 1'b0);
        chk("s4_out0", 32'(fo_a), 32'h0000FFFF);
        chk("s4_err0", 32'(err_a), 32'd0);
        samp(16'hFFFF, 1'b0);
        chk("s4_out1", 32'(fo_a), 32'h0000FFFF);
        chk("s4_err1", 32'(err_a), 32'd1);

        // Reset during the second MAC cycle.
        sdat = 16'd1;
        dr   = 1'b1;
        wait_rise(1'b0);
        dr = 1'b0;
        repeat (2) @(negedge clk);
        chk("s6_err_hold", 32'(err_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("s6_rst_out", 32'(fo_a), 32'd0);
        chk("s6_rst_err", 32'(err_a), 32'd0);
        chk("s6_rst_mw", 32'(mw_a), 32'd0);
        chk("s6_rst_onek", 32'(ok_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        samp(16'd7, 1'b0);
        chk("s6_zero_coeff_out", 32'(fo_a), 32'd0);
        chk("s6_zero_coeff_err", 32'(err_a), 32'd0);
        for (int i = 0; i < 4; i++) load_c(ONE_Q, 1'b0);
        samp(16'd10, 1'b0);
        chk("s6_out10", 32'(fo_a), 32'd17);

        // Request pulse while busy must be dropped.
        sdat = 16'd20;
        dr   = 1'b1;
        wait_rise(1'b0);
        dr = 1'b0;
        repeat (2) @(negedge clk);
        dr = 1'b1;
        repeat (2) @(negedge clk);
        dr = 1'b0;
        wait_fall(1'b0);
        chk("s6_out20", 32'(fo_a), 32'd37);
        samp(16'd30, 1'b0);
        chk("s6_busy_drop", 32'(fo_a), 32'd67);

        // Simultaneous requests: only the coefficient (0 into tap 0) is taken.
        do_op(1'b1, 1'b1, 16'h0000, 16'd99, 1'b0);
        chk("s6_simul_busy", 32'(busy), 32'd1);
        samp(16'd40, 1'b0);
        chk("s6_simul_out", 32'(fo_a), 32'd60);

        // Sample-count pulse with a restart from a coefficient load.
        do_reset();
        for (int i = 0; i < 4; i++) load_c(ONE_Q, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            samp(16'd1, 1'b0);
            chk("s5_pre_onek", 32'(onek_at), 32'd0);
        end
        load_c(ONE_Q, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            samp(16'd1, 1'b0);
            chk("s5_onek", 32'(onek_at), (k % 8 == 0) ? 32'd1 : 32'd0);
            if (k % 8 == 0) chk("s5_onek_1cyc", 32'(onek_after), 32'd0);
        end

        // Eight-tap, 12-bit instance: half gain steps by 50 up to 400.
        do_reset();
        for (int i = 0; i < 8; i++) load_c(16'h0400, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            samp(16'd100, 1'b1);
            chk("w_out", 32'(fo_w), 32'(50 * k));
            chk("w_err", 32'(err_w), 32'd0);
            if (k == 1) chk("w_busy", 32'(busy), 32'd10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
